// File: rtl/smbsb_pkg.sv
// smbsb_pkg: shared types, sizes and helpers for the switch-box frame sequencer
package smbsb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;
  localparam int ADDR_BITS = 2;
  localparam int DATA_BITS = 4;
  localparam int NUM_PORTS = 4;
  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BITS - 1);
  localparam logic [1:0] DATA_LAST = 2'(DATA_BITS - 1);
  function automatic logic [3:0] onehot4(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction
endpackage

// File: rtl/smbsb_frame_ctrl.sv
// smbsb_frame_ctrl: parses start/address/data frames on serin and steers the switch box pb/lb selects
module smbsb_frame_ctrl
  import smbsb_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serin,
  input  logic [3:0] port_en,
  output logic [3:0] pb,
  output logic [1:0] lb,
  output logic       busy,
  output logic       done,
  output logic       drop,
  output logic [1:0] dest
);
  state_t state, nxt;
  logic [1:0] addr, cnt;
  logic en_hit, start;
  assign start = serin == ~IDLE_LEVEL;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      cnt    <= '0;
      en_hit <= 1'b0;
      dest   <= '0;
    end else begin
      state <= nxt;
      if (state == ADDR) addr <= {addr[0], serin};
      cnt <= ((state == ADDR && cnt != ADDR_LAST) || (state == DATA && cnt != DATA_LAST)) ? cnt + 2'd1 : '0;
      // enable is frozen at the last address bit so mid-frame mask changes are ignored
      if (state == ADDR && cnt == ADDR_LAST) en_hit <= port_en[{addr[0], serin}];
      if (state == DATA && cnt == DATA_LAST) dest <= addr;
    end
  end
  always_comb begin
    nxt  = state;
    pb   = '0;
    lb   = '0;
    busy = 1'b0;
    done = 1'b0;
    drop = 1'b0;
    nxt  = state == ADDR ? (cnt == ADDR_LAST ? DATA : ADDR) :
           state == DATA ? (cnt == DATA_LAST ? FIN : DATA) :
           start ? ADDR : IDLE;
    busy = state == ADDR || state == DATA;
    pb   = (state == DATA && en_hit) ? onehot4(addr) : '0;
    lb   = state == DATA ? cnt : '0;
    done = state == FIN && en_hit;
    drop = state == FIN && !en_hit;
  end
endmodule

// File: tb/tb_smbsb_frame_ctrl.sv
// tb_smbsb_frame_ctrl: random and directed frames checked by a scoreboard of routed bits and completions
module tb_smbsb_frame_ctrl;
  logic clk = 0, rst = 1, serin = 1;
  logic [3:0] port_en = '1;
  logic [3:0] pb;
  logic [1:0] lb, dest;
  logic busy, done, drop;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [3:0] pb; logic [1:0] lb; logic b;} route_t;
  typedef struct {logic done; logic drop; logic [1:0] dest; int cyc;} comp_t;
  route_t rq[$];
  comp_t cq[$];

  smbsb_frame_ctrl dut (
    .clk(clk), .rst(rst), .serin(serin), .port_en(port_en),
    .pb(pb), .lb(lb), .busy(busy), .done(done), .drop(drop), .dest(dest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  task automatic tick(input logic b);
    serin = b;
    @(posedge clk);
    #1;
  endtask

  // a frame is accepted iff its port is enabled when the address finishes; every accepted
  // data bit k must appear on port a with lb=k, and the outcome arrives 7 edges after the start bit
  task automatic send_frame(input logic [1:0] a, input logic [3:0] d, input logic [3:0] en,
                            input bit flip, input logic [3:0] en2);
    logic hit;
    logic [3:0] sel;
    port_en = en;
    hit = en[a];
    sel = hit ? (4'b0001 << a) : 4'b0000;
    cq.push_back('{hit, !hit, a, cyc + 7});
    tick(1'b0);
    tick(a[1]);
    tick(a[0]);
    if (flip) port_en = en2;
    for (int k = 0; k < 4; k++) begin
      chk("lb_count", lb, k);
      chk("pb_select", pb, sel);
      chk("busy_data", busy, 1);
      if (hit) rq.push_back('{sel, 2'(k), d[k]});
      tick(d[k]);
    end
    chk("busy_fin", busy, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pb != 4'b0000) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL route_spurious: got pb=%b lb=%0d required no routing", pb, lb);
        end else begin
          route_t r;
          r = rq.pop_front();
          chk("route_pb", pb, r.pb);
          chk("route_lb", lb, r.lb);
          chk("route_bit", serin, r.b);
        end
      end
      if (done || drop) begin
        if (cq.size() == 0) begin
          total++; bad++;
          $display("FAIL comp_spurious: got done=%b drop=%b required none", done, drop);
        end else begin
          comp_t c;
          c = cq.pop_front();
          chk("comp_done", done, c.done);
          chk("comp_drop", drop, c.drop);
          chk("comp_dest", dest, c.dest);
          chk("comp_cycle", cyc, c.cyc);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1;
    tick(1); tick(1);
    rst = 0;
    repeat (10) tick(1);
    chk("rst_pb", pb, 0);
    chk("rst_lb", lb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", drop, 0);
    chk("rst_dest", dest, 0);
    send_frame(2'd2, 4'b1011, 4'b1111, 0, 4'b0000);
    tick(1);
    send_frame(2'd0, 4'b0110, 4'b1110, 0, 4'b0000);
    tick(1);
    send_frame(2'd3, 4'b1001, 4'b1111, 0, 4'b0000);
    send_frame(2'd1, 4'b0111, 4'b1111, 0, 4'b0000);
    tick(1);
    port_en = 4'b1111;
    tick(1'b0); tick(1'b1); tick(1'b0);
    rq.push_back('{4'b0100, 2'd0, 1'b1});
    rq.push_back('{4'b0100, 2'd1, 1'b0});
    tick(1'b1); tick(1'b0);
    rst = 1;
    tick(1);
    rst = 0;
    chk("abort_pb", pb, 0);
    chk("abort_lb", lb, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    tick(1);
    chk("abort_idle_busy", busy, 0);
    send_frame(2'd3, 4'b0101, 4'b1000, 0, 4'b0000);
    tick(1);
    send_frame(2'd1, 4'b1100, 4'b1111, 1, 4'b0000);
    tick(1);
    repeat (150) begin
      logic [1:0] a;
      logic [3:0] d, en, en2;
      a = 2'($urandom);
      d = 4'($urandom);
      en = 4'($urandom);
      en2 = 4'($urandom);
      send_frame(a, d, en, $urandom_range(0, 3) == 0, en2);
      repeat ($urandom_range(0, 2)) tick(1);
    end
    repeat (3) tick(1);
    chk("route_queue_empty", rq.size(), 0);
    chk("comp_queue_empty", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
